conv1_weight_arbiter: RTL

CONV1_WEIGHT_ARBITER -- requirements
Module: conv1_weight_arbiter

---
 rtl/conv1_weight_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/conv1_weight_arbiter.sv
// Shares the single-port conv1 weight RAM between one weight-load writer and two
// round-robin readers; read data comes back three cycles after the request is sampled.
module conv1_weight_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 4,
  parameter int WR_BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd0_req,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic              rd0_gnt,
  output logic              rd0_valid,
  output logic [DATA_W-1:0] rd0_data,
  input  logic              rd1_req,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd1_gnt,
  output logic              rd1_valid,
  output logic [DATA_W-1:0] rd1_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int NUM_RD   = 2;
  localparam int STREAK_W = $clog2(WR_BURST_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(WR_BURST_MAX);

  logic [NUM_RD-1:0]   rd_req;
  logic [NUM_RD-1:0]   rd_elig;
  logic [NUM_RD-1:0]   rd_gnt_reg, rd_gnt_next;
  logic                wr_elig, cap_hit;
  logic                wr_gnt_reg, wr_gnt_next;
  logic [STREAK_W-1:0] wr_streak_reg, wr_streak_next;
  logic                rr_ptr_reg, rr_ptr_next;  // index of the reader that wins the next tie
  logic                ram_en_reg, ram_we_reg;
  logic [ADDR_W-1:0]   ram_addr_reg, ram_addr_next;
  logic [DATA_W-1:0]   ram_wdata_reg, ram_wdata_next;
  logic [1:0]          tag_vld_reg;
  logic [1:0]          tag_id_reg;

  assign rd_req = {rd1_req, rd0_req};

  always_comb begin
    // A requester still holding req during its own grant cycle must not win again.
    rd_elig        = rd_req & ~rd_gnt_reg;
    wr_elig        = wr_req & ~wr_gnt_reg;
    cap_hit        = (wr_streak_reg == STREAK_MAX) && (|rd_elig);
    wr_gnt_next    = 1'b0;
    rd_gnt_next    = '0;
    rr_ptr_next    = rr_ptr_reg;
    wr_streak_next = '0;
    ram_addr_next  = ram_addr_reg;
    ram_wdata_next = ram_wdata_reg;

    if (wr_elig && !cap_hit) begin
      wr_gnt_next = 1'b1;
    end else if (&rd_elig) begin
      rd_gnt_next[rr_ptr_reg] = 1'b1;
    end else begin
      rd_gnt_next = rd_elig;
    end

    if (rd_gnt_next[0]) begin
      rr_ptr_next = 1'b1;
    end else if (rd_gnt_next[1]) begin
      rr_ptr_next = 1'b0;
    end

    if (wr_gnt_next) begin
      wr_streak_next = (wr_streak_reg == STREAK_MAX) ? wr_streak_reg
                                                     : wr_streak_reg + STREAK_W'(1);
    end

    if (wr_gnt_next) begin
      ram_addr_next  = wr_addr;
      ram_wdata_next = wr_data;
    end else if (rd_gnt_next[1]) begin
      ram_addr_next = rd1_addr;
    end else if (rd_gnt_next[0]) begin
      ram_addr_next = rd0_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_gnt_reg    <= '0;
      wr_gnt_reg    <= 1'b0;
      wr_streak_reg <= '0;
      rr_ptr_reg    <= 1'b0;
      ram_en_reg    <= 1'b0;
      ram_we_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
      tag_vld_reg   <= '0;
      tag_id_reg    <= '0;
    end else begin
      rd_gnt_reg    <= rd_gnt_next;
      wr_gnt_reg    <= wr_gnt_next;
      wr_streak_reg <= wr_streak_next;
      rr_ptr_reg    <= rr_ptr_next;
      ram_en_reg    <= wr_gnt_next | (|rd_gnt_next);
      ram_we_reg    <= wr_gnt_next;
      ram_addr_reg  <= ram_addr_next;
      ram_wdata_reg <= ram_wdata_next;
      // Stage 0 lines up with the RAM access, stage 1 with ram_rdata.
      tag_vld_reg   <= {tag_vld_reg[0], |rd_gnt_next};
      tag_id_reg    <= {tag_id_reg[0], rd_gnt_next[1]};
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_ret
      logic              valid_reg;
      logic [DATA_W-1:0] data_reg;
      logic              hit;

      assign hit = tag_vld_reg[1] && (tag_id_reg[1] == 1'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          valid_reg <= hit;
          if (hit) begin
            data_reg <= ram_rdata;
          end
        end
      end
    end
  endgenerate

  assign rd0_gnt   = rd_gnt_reg[0];
  assign rd1_gnt   = rd_gnt_reg[1];
  assign wr_gnt    = wr_gnt_reg;
  assign rd0_valid = g_ret[0].valid_reg;
  assign rd1_valid = g_ret[1].valid_reg;
  assign rd0_data  = g_ret[0].data_reg;
  assign rd1_data  = g_ret[1].data_reg;
  assign ram_en    = ram_en_reg;
  assign ram_we    = ram_we_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_wdata = ram_wdata_reg;

endmodule
